// File: rtl/seq_detector_param_if.sv
// Serial pattern detector bus: bit stream, pattern reload and match outputs.
// Parameterised to match the detector's PATTERN_W and COUNT_W.
interface seq_detector_param_if #(
    parameter int PATTERN_W = 4,
    parameter int COUNT_W   = 8
);
    logic                 x;
    logic                 x_valid;
    logic                 pat_load;
    logic [PATTERN_W-1:0] pat_in;
    logic                 cnt_clr;
    logic                 z;
    logic [COUNT_W-1:0]   match_count;

    modport master (
        output x, x_valid, pat_load, pat_in, cnt_clr,
        input  z, match_count
    );

    modport slave (
        input  x, x_valid, pat_load, pat_in, cnt_clr,
        output z, match_count
    );
endinterface

// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector with runtime-loadable pattern.
// Define SEQ_DET_COUNT_EN to build the saturating match counter.
module seq_detector_param #(
    parameter int                   PATTERN_W = 4,
    parameter logic [PATTERN_W-1:0] PATTERN   = 4'b0110,
    parameter bit                   OVERLAP   = 1'b1,
    parameter int                   COUNT_W   = 8
) (
    input logic            clk,
    input logic            reset,
    seq_detector_param_if.slave bus
);
    localparam int FW = $clog2(PATTERN_W + 1);
    localparam logic [FW-1:0] FILL_MAX = FW'(PATTERN_W);
    localparam logic [FW-1:0] FILL_PRE = FW'(PATTERN_W - 1);

    logic [PATTERN_W-1:0] hist;
    logic [PATTERN_W-1:0] pattern;
    logic [PATTERN_W-1:0] nxt;
    logic [FW-1:0]        fill;
    logic                 z_q;
    logic                 match;

    assign nxt   = {hist[PATTERN_W-2:0], bus.x};
    assign match = bus.x_valid && !bus.pat_load &&
                   (fill >= FILL_PRE) && (nxt == pattern);

    always_ff @(posedge clk) begin
        if (!reset) begin
            hist    <= '0;
            fill    <= '0;
            pattern <= PATTERN;
            z_q     <= 1'b0;
        end else begin
            z_q <= 1'b0;
            if (bus.pat_load) begin
                pattern <= bus.pat_in;
                hist    <= '0;
                fill    <= '0;
            end else if (bus.x_valid) begin
                hist <= nxt;
                z_q  <= match;
                // Non-overlap mode restarts the fill so match bits are not reused
                if (match && !OVERLAP)
                    fill <= '0;
                else if (fill != FILL_MAX)
                    fill <= fill + 1'b1;
            end
        end
    end

    assign bus.z = z_q;

`ifdef SEQ_DET_COUNT_EN
    logic [COUNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset)
            count <= '0;
        else if (bus.cnt_clr)
            count <= '0;
        else if (match && count != {COUNT_W{1'b1}})
            count <= count + 1'b1;
    end

    assign bus.match_count = count;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr  = bus.cnt_clr;
    assign bus.match_count = '0;
`endif
endmodule
